// File: rtl/mio_mem_responder.sv
// Single-port memory responder for a CPU memory-I/O strobe: a request is accepted in IDLE,
// waits LATENCY cycles, then completes with a one-cycle MIO_ready pulse.
module mio_mem_responder #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              CPU_MIO,
  input  logic              mem_w,
  input  logic [31:0]       addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] Data_in,
  output logic              MIO_ready,
  output logic              err,
  output logic              busy,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data
);

  localparam int         DEPTH = 2 ** ADDR_W;
  localparam logic [3:0] LAT   = 4'(LATENCY);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t              state_reg, state_next;
  logic [3:0]          cnt_reg, cnt_next;
  logic                enter_resp;

  logic                req_we_reg;
  logic                req_bad_reg;
  logic [ADDR_W-1:0]   req_word_reg;
  logic [DATA_W-1:0]   req_wdata_reg;

  logic [DATA_W-1:0]   data_reg;
  logic                err_reg;

  logic [DATA_W-1:0]   mem [DEPTH];

  // Decode of the request currently on the CPU port.
  logic [ADDR_W-1:0]   in_word;
  logic                in_bad;

  assign in_word = addr[ADDR_W+1:2];
  assign in_bad  = (addr[1:0] != 2'b00) || ((addr >> (ADDR_W + 2)) != 32'd0);

  // With zero latency RESP is entered on the accepting edge itself, so the
  // live port fields must be used before they have been latched.
  logic                cur_we;
  logic                cur_bad;
  logic [ADDR_W-1:0]   cur_word;

  assign cur_we   = (state_reg == IDLE) ? mem_w   : req_we_reg;
  assign cur_bad  = (state_reg == IDLE) ? in_bad  : req_bad_reg;
  assign cur_word = (state_reg == IDLE) ? in_word : req_word_reg;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    enter_resp = 1'b0;
    case (state_reg)
      IDLE: begin
        if (CPU_MIO) begin
          cnt_next = LAT;
          if (LAT == 4'd0) begin
            state_next = RESP;
            enter_resp = 1'b1;
          end else begin
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_next = cnt_reg - 4'd1;
        if (cnt_reg <= 4'd1) begin
          state_next = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP: begin
        state_next = IDLE;
        cnt_next   = 4'd0;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      req_we_reg    <= 1'b0;
      req_bad_reg   <= 1'b0;
      req_word_reg  <= '0;
      req_wdata_reg <= '0;
    end else if (state_reg == IDLE && CPU_MIO) begin
      req_we_reg    <= mem_w;
      req_bad_reg   <= in_bad;
      req_word_reg  <= in_word;
      req_wdata_reg <= wdata;
    end
  end

  // Response registers hold their value until the next completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_reg <= '0;
      err_reg  <= 1'b0;
    end else if (enter_resp) begin
      err_reg  <= cur_bad;
      data_reg <= (cur_we || cur_bad) ? '0 : mem[cur_word];
    end
  end

  // Preload is written last so it wins over a CPU write to the same word.
  always_ff @(posedge clk) begin
    if (!reset && state_reg == RESP && req_we_reg && !req_bad_reg) begin
      mem[req_word_reg] <= req_wdata_reg;
    end
    if (ld_en) begin
      mem[ld_addr] <= ld_data;
    end
  end

  assign Data_in   = data_reg;
  assign err       = err_reg;
  assign MIO_ready = (state_reg == RESP);
  assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_mio_mem_responder.sv
// Bench for mio_mem_responder: three instances (LATENCY 0, 1, 3) checked every cycle
// against a transaction-level model, plus directed literal expectations.
module tb_mio_mem_responder;

  localparam int AW    = 10;
  localparam int DW    = 32;
  localparam int DEPTH = 1024;

  logic          clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [2:0]    cpu_mio;
  logic          mem_w;
  logic [31:0]   addr;
  logic [31:0]   wdata;
  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [31:0]   ld_data;

  logic [31:0]   data_w [3];
  logic [2:0]    ready_w, err_w, busy_w;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  function automatic int lat_of(input int i);
    return (i == 0) ? 0 : ((i == 1) ? 1 : 3);
  endfunction

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      mio_mem_responder #(
        .DATA_W (DW),
        .ADDR_W (AW),
        .LATENCY((gi == 0) ? 0 : ((gi == 1) ? 1 : 3))
      ) u_dut (
        .clk      (clk),
        .reset    (rst),
        .CPU_MIO  (cpu_mio[gi]),
        .mem_w    (mem_w),
        .addr     (addr),
        .wdata    (wdata),
        .Data_in  (data_w[gi]),
        .MIO_ready(ready_w[gi]),
        .err      (err_w[gi]),
        .busy     (busy_w[gi]),
        .ld_en    (ld_en),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data)
      );
    end
  endgenerate

  // Transaction-level model: one outstanding request per instance, timed by edge number.
  logic [31:0] m_mem [3][DEPTH];
  int          edge_n = 0;
  bit          m_act [3];
  int          m_t [3];
  bit          m_we [3];
  bit          m_bad [3];
  int          m_word [3];
  logic [31:0] m_wd [3];
  logic [31:0] exp_data [3];
  bit          exp_err [3];
  bit          exp_ready [3];

  always @(posedge clk) begin
    edge_n++;
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        m_act[i]    = 1'b0;
        exp_data[i] = 32'd0;
        exp_err[i]  = 1'b0;
      end else begin
        if (m_act[i] && edge_n == m_t[i] + lat_of(i) + 1) begin
          if (m_we[i] && !m_bad[i]) m_mem[i][m_word[i]] = m_wd[i];
          m_act[i] = 1'b0;
        end else if (!m_act[i] && cpu_mio[i]) begin
          m_act[i]  = 1'b1;
          m_t[i]    = edge_n;
          m_we[i]   = mem_w;
          m_bad[i]  = (addr % 4 != 0) || (addr >= 32'(4 * DEPTH));
          m_word[i] = int'((addr / 4) % DEPTH);
          m_wd[i]   = wdata;
        end
        if (m_act[i] && edge_n == m_t[i] + lat_of(i)) begin
          exp_err[i]  = m_bad[i];
          exp_data[i] = (m_we[i] || m_bad[i]) ? 32'd0 : m_mem[i][m_word[i]];
        end
      end
      if (ld_en) m_mem[i][ld_addr] = ld_data;
      exp_ready[i] = m_act[i] && (edge_n == m_t[i] + lat_of(i));
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        tests++;
        if (ready_w[i] !== exp_ready[i] || busy_w[i] !== m_act[i] ||
            data_w[i] !== exp_data[i] || err_w[i] !== exp_err[i]) begin
          fails++;
          $display("FAIL model_cmp inst%0d edge %0d: got ready=%b busy=%b err=%b data=%h, expected ready=%b busy=%b err=%b data=%h",
                   i, edge_n, ready_w[i], busy_w[i], err_w[i], data_w[i],
                   exp_ready[i], m_act[i], exp_err[i], exp_data[i]);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end else begin
      $display("[TB] ok %s = %h", nm, got);
    end
  endtask

  // Issue one request and return at the negedge of its completion cycle.
  task automatic do_req(input int i, input bit w, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] got, output logic gerr, output int n);
    @(negedge clk);
    cpu_mio[i] = 1'b1;
    mem_w      = w;
    addr       = a;
    wdata      = d;
    @(negedge clk);
    cpu_mio[i] = 1'b0;
    n = 1;
    while (!ready_w[i] && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!ready_w[i]) begin
      tests++;
      fails++;
      $display("FAIL timeout inst%0d addr %h: got no MIO_ready, required one within 40 cycles", i, a);
    end
    got  = data_w[i];
    gerr = err_w[i];
  endtask

  logic [31:0] got;
  logic        gerr;
  int          n;
  logic [5:0]  pat;

  initial begin
    rst = 1'b1; cpu_mio = 3'b000; mem_w = 1'b0; addr = 32'd0; wdata = 32'd0;
    ld_en = 1'b0; ld_addr = '0; ld_data = 32'd0;
    @(posedge clk);
    #1 chk_en = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      @(negedge clk);
      ld_en = 1'b1; ld_addr = AW'(k); ld_data = 32'hA5A5_0000 | 32'(k);
    end
    @(negedge clk); ld_addr = AW'(2); ld_data = 32'h0800_0003;
    @(negedge clk); ld_addr = AW'(1); ld_data = 32'h200A_000A;
    @(negedge clk); ld_en = 1'b0; rst = 1'b0;
    chk("reset_data", data_w[1], 32'd0);
    chk("reset_busy", 32'(busy_w[1]), 32'd0);

    // LATENCY=1 read of preloaded word 2
    do_req(1, 1'b0, 32'h8, 32'd0, got, gerr, n);
    chk("l1_read_lat", 32'(n), 32'd2);
    chk("l1_read_data", got, 32'h0800_0003);
    chk("l1_read_err", 32'(gerr), 32'd0);

    // LATENCY=0 write then read, then back-to-back with strobe held
    do_req(0, 1'b1, 32'hC, 32'h0120_0009, got, gerr, n);
    chk("l0_write_lat", 32'(n), 32'd1);
    chk("l0_write_data", got, 32'd0);
    do_req(0, 1'b0, 32'hC, 32'd0, got, gerr, n);
    chk("l0_read_data", got, 32'h0120_0009);
    @(negedge clk);
    cpu_mio[0] = 1'b1; mem_w = 1'b0; addr = 32'hC;
    pat = 6'd0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      pat = {pat[4:0], ready_w[0]};
    end
    cpu_mio[0] = 1'b0;
    chk("l0_held_pattern", 32'(pat), 32'b101010);

    // Address errors and aliasing write
    do_req(1, 1'b0, 32'h6, 32'd0, got, gerr, n);
    chk("misaligned_err", 32'(gerr), 32'd1);
    chk("misaligned_data", got, 32'd0);
    do_req(1, 1'b0, 32'h1000, 32'd0, got, gerr, n);
    chk("range_err", 32'(gerr), 32'd1);
    chk("range_data", got, 32'd0);
    do_req(1, 1'b1, 32'h1000, 32'hFFFF_FFFF, got, gerr, n);
    chk("range_write_err", 32'(gerr), 32'd1);
    do_req(1, 1'b0, 32'h0, 32'd0, got, gerr, n);
    chk("word0_unchanged", got, 32'hA5A5_0000);

    // Preload and CPU write commit to word 5 on the same edge
    do_req(1, 1'b1, 32'h14, 32'h1111_1111, got, gerr, n);
    ld_en = 1'b1; ld_addr = AW'(5); ld_data = 32'h2222_2222;
    @(negedge clk); ld_en = 1'b0;
    do_req(1, 1'b0, 32'h14, 32'd0, got, gerr, n);
    chk("preload_wins", got, 32'h2222_2222);

    // Preload to word 2 on the edge entering RESP returns the old value
    @(negedge clk);
    cpu_mio[1] = 1'b1; mem_w = 1'b0; addr = 32'h8;
    @(negedge clk);
    cpu_mio[1] = 1'b0; ld_en = 1'b1; ld_addr = AW'(2); ld_data = 32'h5555_5555;
    @(negedge clk);
    ld_en = 1'b0;
    chk("pre_preload_ready", 32'(ready_w[1]), 32'd1);
    chk("pre_preload_data", data_w[1], 32'h0800_0003);

    // LATENCY=3 read with strobe and address churning during WAIT
    @(negedge clk);
    cpu_mio[2] = 1'b1; mem_w = 1'b0; addr = 32'h8;
    @(negedge clk); cpu_mio[2] = 1'b0; addr = 32'h14;
    @(negedge clk); cpu_mio[2] = 1'b1; addr = 32'h7; mem_w = 1'b1;
    @(negedge clk); cpu_mio[2] = 1'b0; addr = 32'h10; mem_w = 1'b0;
    @(negedge clk);
    chk("l3_churn_ready", 32'(ready_w[2]), 32'd1);
    chk("l3_churn_data", data_w[2], 32'h5555_5555);
    chk("l3_churn_err", 32'(err_w[2]), 32'd0);

    // Reset during the second WAIT cycle aborts a LATENCY=3 write
    @(negedge clk);
    cpu_mio[2] = 1'b1; mem_w = 1'b1; addr = 32'h4; wdata = 32'hDEAD_BEEF;
    @(negedge clk); cpu_mio[2] = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("abort_busy", 32'(busy_w[2]), 32'd0);
    chk("abort_data", data_w[2], 32'd0);
    repeat (6) @(negedge clk);
    do_req(2, 1'b0, 32'h4, 32'd0, got, gerr, n);
    chk("abort_lat", 32'(n), 32'd4);
    chk("abort_word1", got, 32'h200A_000A);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required one within 200000 time units");
    $fatal(1);
  end

endmodule
